// File: rtl/param_fifo_pkg.sv
// Shared definitions for the param_fifo slice.
//   FIFO_STD / FIFO_FWFT : read-mode selectors for the FWFT parameter
//   fwft_state_e         : output-stage state for first-word-fall-through mode
//   clog2                : integer ceiling log2 helper
//   levels_ok            : elaboration check of depth against the flag thresholds
package param_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  typedef enum logic [1:0] {
    FWFT_EMPTY    = 2'd0,
    FWFT_PREFETCH = 2'd1,
    FWFT_VALID    = 2'd2
  } fwft_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  // Thresholds must lie inside 0..depth, and the mode must be one of the two selectors.
  function automatic bit levels_ok(input int addr_bits, input int af_level,
                                   input int ae_level, input int fwft);
    int depth;
    depth = 1 << addr_bits;
    return (addr_bits >= 1) &&
           (af_level >= 0) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth) &&
           ((fwft == FIFO_STD) || (fwft == FIFO_FWFT));
  endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Handshake bundle between a FIFO and its producer/consumer.
//   master : producer/consumer side (drives wr, wr_data, rd)
//   slave  : FIFO side (drives data out, flags, occupancy, sticky error flags)
interface param_fifo_if #(
  parameter int DATA_BITS = 64,
  parameter int ADDR_BITS = 10
);

  logic                 wr;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_full;
  logic                 almost_full;
  logic                 rd;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_empty;
  logic                 almost_empty;
  logic [ADDR_BITS:0]   words_avail;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output wr, wr_data, rd,
    input  wr_full, almost_full, rd_data, rd_empty, almost_empty,
           words_avail, overflow, underflow
  );

  modport slave (
    input  wr, wr_data, rd,
    output wr_full, almost_full, rd_data, rd_empty, almost_empty,
           words_avail, overflow, underflow
  );

endinterface

// File: rtl/param_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
//   clk   : clock
//   aclr  : synchronous active-high clear of the read register only
//   we/waddr/wdata : write port
//   re/raddr       : read enable/address; rdata updates on the enabling edge
//   rdata          : registered read data
// A write and a read of the same address on one edge return the old word.
module param_fifo_sdp_ram #(
  parameter int DATA_BITS = 64,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  (* ram_style = "block" *) logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (aclr)    rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with full 2^ADDR_BITS capacity and exact count.
//   clk, aclr   : clock and synchronous active-high reset
//   bus (slave) : wr/wr_data/wr_full/almost_full, rd/rd_data/rd_empty/almost_empty,
//                 words_avail, sticky overflow/underflow
//   peak_words  : only when PARAM_FIFO_PEAK_EN is defined; highest words_avail since reset
// FWFT=FIFO_STD : rd_data is loaded on the edge that accepts rd.
// FWFT=FIFO_FWFT: rd_data presents the head word whenever rd_empty=0; rd pops it.
// All flags are registered from the next-state count.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int DATA_BITS = 64,
  parameter int ADDR_BITS = 10,
  parameter int FWFT      = FIFO_STD,
  parameter int AF_LEVEL  = (1 << ADDR_BITS) - 4,
  parameter int AE_LEVEL  = 4
) (
  input  logic clk,
  input  logic aclr,
`ifdef PARAM_FIFO_PEAK_EN
  output logic [ADDR_BITS:0] peak_words,
`endif
  param_fifo_if.slave bus
);

  localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(1 << ADDR_BITS);
  localparam logic [ADDR_BITS:0] AF_C    = (ADDR_BITS+1)'(AF_LEVEL);
  localparam logic [ADDR_BITS:0] AE_C    = (ADDR_BITS+1)'(AE_LEVEL);
  localparam logic [ADDR_BITS-1:0] PTR_ZERO = '0;
  localparam logic [ADDR_BITS:0]   CNT_ZERO = '0;

  if (!levels_ok(ADDR_BITS, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_bad_params
    $error("param_fifo: AF_LEVEL/AE_LEVEL outside 0..depth or FWFT not 0/1");
  end

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 wr_full_q, wr_full_d;
  logic                 af_q, af_d;
  logic                 rd_empty_q, rd_empty_d;
  logic                 ae_q, ae_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  logic                 wr_acc;
  logic                 rd_acc;
  logic                 ram_rd;
  logic [DATA_BITS-1:0] ram_rdata;

  // A write while full is still taken when a read frees the slot on the same edge.
  always_comb begin
    rd_acc   = bus.rd & ~rd_empty_q;
    wr_acc   = bus.wr & (~wr_full_q | rd_acc);
    count_d  = count_q + {CNT_ZERO[ADDR_BITS:1], wr_acc} - {CNT_ZERO[ADDR_BITS:1], rd_acc};
    wr_ptr_d = wr_ptr_q + {PTR_ZERO[ADDR_BITS-1:1], wr_acc};
    rd_ptr_d = rd_ptr_q + {PTR_ZERO[ADDR_BITS-1:1], ram_rd};
    wr_full_d = (count_d == DEPTH_C);
    af_d      = (count_d >= AF_C);
    ae_d      = (count_d <= AE_C);
    ovf_d     = ovf_q | (bus.wr & ~wr_acc);
    udf_d     = udf_q | (bus.rd & rd_empty_q);
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_full_q  <= 1'b0;
      af_q       <= 1'b0;
      rd_empty_q <= 1'b1;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_full_q  <= wr_full_d;
      af_q       <= af_d;
      rd_empty_q <= rd_empty_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    fwft_state_e        state_q, state_d;
    logic [ADDR_BITS:0] ram_words;

    // count includes the word parked in the output register.
    assign ram_words = count_q - {CNT_ZERO[ADDR_BITS:1], (state_q == FWFT_VALID)};

    always_ff @(posedge clk) begin
      if (aclr) state_q <= FWFT_EMPTY;
      else      state_q <= state_d;
    end

    // A pop refetches on the same edge when the RAM has a word, so the output never gaps.
    // PREFETCH is the one cycle spent fetching a word that was written into an idle stage.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        FWFT_EMPTY:    if (wr_acc) state_d = FWFT_PREFETCH;
        FWFT_PREFETCH: state_d = FWFT_VALID;
        FWFT_VALID: begin
          if (rd_acc) begin
            if (ram_words != CNT_ZERO) state_d = FWFT_VALID;
            else if (wr_acc)           state_d = FWFT_PREFETCH;
            else                       state_d = FWFT_EMPTY;
          end
        end
        default:       state_d = FWFT_EMPTY;
      endcase
    end

    always_comb begin
      ram_rd     = (state_q == FWFT_PREFETCH) |
                   ((state_q == FWFT_VALID) & rd_acc & (ram_words != CNT_ZERO));
      rd_empty_d = (state_d != FWFT_VALID);
    end
  end else begin : g_std
    always_comb begin
      ram_rd     = rd_acc;
      rd_empty_d = (count_d == CNT_ZERO);
    end
  end

  param_fifo_sdp_ram #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .aclr  (aclr),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .re    (ram_rd),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

`ifdef PARAM_FIFO_PEAK_EN
  logic [ADDR_BITS:0] peak_q, peak_d;

  // Tracks count_d so the peak lines up with the registered words_avail.
  always_comb begin
    peak_d = (count_d > peak_q) ? count_d : peak_q;
  end

  always_ff @(posedge clk) begin
    if (aclr) peak_q <= '0;
    else      peak_q <= peak_d;
  end

  assign peak_words = peak_q;
`endif

  assign bus.rd_data      = ram_rdata;
  assign bus.wr_full      = wr_full_q;
  assign bus.almost_full  = af_q;
  assign bus.rd_empty     = rd_empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.words_avail  = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule
